// File: rtl/student_iic_master.sv
// student_iic_master: I2C master byte engine that sequences START/WRITE/READ/STOP on open-drain SCL/SDA pads
module student_iic_master #(
   parameter int CLK_DIV = 125
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [1:0] cmd_i,
   input  logic [7:0] wdata_i,
   input  logic       mack_i,
   output logic       rsp_valid_o,
   output logic [7:0] rdata_o,
   output logic       ack_o,
   output logic       err_o,
   output logic       bus_active_o,
   output logic       scl_pull_o,
   output logic       sda_pull_o,
   input  logic       scl_i,
   input  logic       sda_i
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [1:0] C_START = 2'd0, C_READ = 2'd2, C_STOP = 2'd3;

   typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, RESP} state_t;

   state_t          r_state, w_state_n;
   logic [1:0]      r_phase, w_phase_n;
   logic [CW-1:0]   r_cnt, w_cnt_n;
   logic [2:0]      r_bit, w_bit_n;
   logic [7:0]      r_sh, w_sh_n;
   logic [7:0]      r_rdata, w_rdata_n;
   logic            r_rd, w_rd_n;
   logic            r_mack, w_mack_n;
   logic            r_ack, w_ack_n;
   logic            r_err, w_err_n;
   logic            r_bus, w_bus_n;
   logic            r_scl, w_scl_n;
   logic            r_sda, w_sda_n;
   logic            r_ready;
   logic            r_scl_m, r_scl_s, r_sda_m, r_sda_s;
   logic            w_tick, w_adv, w_enter;

   assign w_tick = r_cnt == LAST;
   // a phase with SCL released only ends once the synchronised line reads high (clock stretching)
   assign w_adv  = w_tick && (r_scl || r_scl_s);

   always_comb begin
      w_state_n = r_state;
      w_phase_n = r_phase;
      w_cnt_n   = r_cnt;
      w_bit_n   = r_bit;
      w_sh_n    = r_sh;
      w_rdata_n = r_rdata;
      w_rd_n    = r_rd;
      w_mack_n  = r_mack;
      w_ack_n   = r_ack;
      w_err_n   = r_err;
      w_bus_n   = r_bus;
      w_scl_n   = r_scl;
      w_sda_n   = r_sda;
      w_enter   = 1'b0;
      case (r_state)
         IDLE: if (cmd_valid_i && r_ready) begin
            w_enter   = 1'b1;
            w_rd_n    = cmd_i == C_READ;
            w_mack_n  = mack_i;
            w_sh_n    = wdata_i;
            w_cnt_n   = '0;
            w_phase_n = '0;
            w_bit_n   = '0;
            w_err_n   = cmd_i != C_START && !r_bus;
            w_state_n = w_err_n ? RESP : cmd_i == C_START ? START : cmd_i == C_STOP ? STOP : BIT;
         end
         RESP: w_state_n = IDLE;
         default: begin
            w_cnt_n = w_adv ? '0 : w_tick ? r_cnt : r_cnt + 1'b1;
            if (w_adv) begin
               w_enter   = 1'b1;
               w_phase_n = r_phase + 1'b1;
               if (r_phase == 2'd2 && r_state == BIT) w_sh_n = {r_sh[6:0], r_sda_s};
               if (r_phase == 2'd2 && r_state == ACK && !r_rd) w_ack_n = !r_sda_s;
               if (r_phase == 2'd3) begin
                  w_bit_n   = r_state == BIT ? r_bit + 1'b1 : r_bit;
                  w_state_n = (r_state == BIT && r_bit != 3'd7) ? BIT : r_state == BIT ? ACK : RESP;
                  w_bus_n   = r_state == START ? 1'b1 : r_state == STOP ? 1'b0 : r_bus;
                  w_rdata_n = (r_state == ACK && r_rd) ? r_sh : r_rdata;
               end
            end
         end
      endcase
      // pad levels are set once, on entry to each phase, and held for its duration
      if (w_enter && w_state_n != RESP) begin
         if (w_phase_n == 2'd1) w_scl_n = 1'b0;
         if (w_phase_n == 2'd3 && w_state_n != STOP) w_scl_n = 1'b1;
         if (w_phase_n == 2'd0)
            w_sda_n = w_state_n == STOP ||
                      (w_state_n == BIT ? !w_rd_n && !w_sh_n[7] : w_state_n == ACK && w_rd_n && w_mack_n);
         if (w_phase_n == 2'd2 && (w_state_n == START || w_state_n == STOP))
            w_sda_n = w_state_n == START;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_phase <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_sh    <= '0;
         r_rdata <= '0;
         r_rd    <= 1'b0;
         r_mack  <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_bus   <= 1'b0;
         r_scl   <= 1'b0;
         r_sda   <= 1'b0;
         r_ready <= 1'b0;
         r_scl_m <= 1'b1;
         r_scl_s <= 1'b1;
         r_sda_m <= 1'b1;
         r_sda_s <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_phase <= w_phase_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_sh    <= w_sh_n;
         r_rdata <= w_rdata_n;
         r_rd    <= w_rd_n;
         r_mack  <= w_mack_n;
         r_ack   <= w_ack_n;
         r_err   <= w_err_n;
         r_bus   <= w_bus_n;
         r_scl   <= w_scl_n;
         r_sda   <= w_sda_n;
         r_ready <= w_state_n == IDLE;
         r_scl_m <= scl_i;
         r_scl_s <= r_scl_m;
         r_sda_m <= sda_i;
         r_sda_s <= r_sda_m;
      end
   end

   assign cmd_ready_o  = r_ready;
   assign rsp_valid_o  = r_state == RESP;
   assign rdata_o      = r_rdata;
   assign ack_o        = r_ack;
   assign err_o        = r_err;
   assign bus_active_o = r_bus;
   assign scl_pull_o   = r_scl;
   assign sda_pull_o   = r_sda;
endmodule

// File: tb/tb_student_iic_master.sv
// tb_student_iic_master: directed/random command sequence against an I2C slave and bus monitor on open-drain pads
module tb_student_iic_master;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_ni, cmd_valid_i, mack_i;
   logic [1:0] cmd_i;
   logic [7:0] wdata_i;
   logic       cmd_ready_o, rsp_valid_o, ack_o, err_o, bus_active_o, scl_pull_o, sda_pull_o;
   logic [7:0] rdata_o;
   logic       w_scl, w_sda;
   logic       s_scl_pull = 1'b0, s_sda_pull = 1'b0;

   int         ncmp = 0, nerr = 0;
   int         n_start = 0, n_stop = 0, n_pinchg = 0;
   logic       bits_q[$];
   int         s_mode = 0, st_req = 0;
   logic [7:0] s_tx = 8'h00;
   logic       s_ack = 1'b0;
   logic       m_bus = 1'b0, m_ack = 1'b0;
   logic [7:0] m_rdata = 8'h00;

   always #5 clk = ~clk;

   assign w_scl = ~(scl_pull_o | s_scl_pull);
   assign w_sda = ~(sda_pull_o | s_sda_pull);

   student_iic_master #(.CLK_DIV(D)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_i(cmd_i), .wdata_i(wdata_i), .mack_i(mack_i), .rsp_valid_o(rsp_valid_o),
      .rdata_o(rdata_o), .ack_o(ack_o), .err_o(err_o), .bus_active_o(bus_active_o),
      .scl_pull_o(scl_pull_o), .sda_pull_o(sda_pull_o), .scl_i(w_scl), .sda_i(w_sda)
   );

   // bus monitor and slave: bits on SCL rise, START/STOP on SDA edges with SCL high
   initial begin
      logic p_scl, p_sda, p_sp, p_dp;
      int   idx, st_cnt, st_ack;
      p_scl = 1'b1; p_sda = 1'b1; p_sp = 1'b0; p_dp = 1'b0;
      idx = 8; st_cnt = 0; st_ack = 0;
      forever begin
         @(negedge clk);
         if (!p_scl && w_scl) bits_q.push_back(w_sda);
         if (p_scl && w_scl && p_sda && !w_sda) begin n_start++; idx = 8; end
         if (p_scl && w_scl && !p_sda && w_sda) n_stop++;
         if (p_scl && !w_scl) begin
            idx = (idx == 8) ? 0 : idx + 1;
            if (idx == 3 && s_mode == 1 && st_req != st_ack) begin st_ack = st_req; st_cnt = 50; end
         end
         s_scl_pull = st_cnt > 0;
         if (st_cnt > 0) st_cnt--;
         if (scl_pull_o != p_sp || sda_pull_o != p_dp) n_pinchg++;
         if (s_mode == 0) s_sda_pull = 1'b0;
         else if (!w_scl) s_sda_pull = (s_mode == 1) ? (idx == 8 && s_ack) : (idx < 8 && !s_tx[7-idx]);
         p_scl = w_scl; p_sda = w_sda; p_sp = scl_pull_o; p_dp = sda_pull_o;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // slack>0: slave stretches SCL ~slack cycles, latency accepted within a window around it
   task automatic run_cmd(input string tag, input logic [1:0] c, input logic [7:0] d, input logic m,
                          input logic sa, input logic [7:0] tx, input int slack);
      int lat, n, b0, s0, p0, c0, e_lat;
      logic e_err;
      logic [8:0] e_bits, got;
      s_mode = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : 0;
      s_tx = tx;
      s_ack = sa;
      n = 0;
      while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_ready"}, cmd_ready_o, 1);
      b0 = bits_q.size(); s0 = n_start; p0 = n_stop; c0 = n_pinchg;
      cmd_i = c; wdata_i = d; mack_i = m; cmd_valid_i = 1'b1;
      @(negedge clk);
      cmd_valid_i = 1'b0; cmd_i = 2'($urandom); wdata_i = 8'($urandom); mack_i = 1'($urandom);
      lat = 1;
      while (!rsp_valid_o && lat < 3000) begin @(negedge clk); lat++; end
      e_err = c != 2'd0 && !m_bus;
      e_lat = e_err ? 1 : (c == 2'd1 || c == 2'd2) ? 36 * D + 1 : 4 * D + 1;
      if (!e_err) begin
         if (c == 2'd0) m_bus = 1'b1;
         if (c == 2'd3) m_bus = 1'b0;
         if (c == 2'd1) m_ack = sa;
         if (c == 2'd2) m_rdata = tx;
      end
      if (slack == 0) chk({tag, "_latency"}, lat, e_lat);
      else chk({tag, "_stretch_latency"}, lat >= e_lat + slack - 20 && lat <= e_lat + slack + 5, 1);
      chk({tag, "_rsp"}, rsp_valid_o, 1);
      chk({tag, "_err"}, err_o, e_err);
      chk({tag, "_bus_active"}, bus_active_o, m_bus);
      chk({tag, "_rdata"}, rdata_o, m_rdata);
      if (c == 2'd1 && !e_err) chk({tag, "_ack"}, ack_o, m_ack);
      if (!e_err && (c == 2'd1 || c == 2'd2)) begin
         e_bits = (c == 2'd1) ? {d, ~sa} : {tx, ~m};
         chk({tag, "_nbits"}, bits_q.size() - b0, 9);
         got = '0;
         if (bits_q.size() >= b0 + 9) for (int i = 0; i < 9; i++) got = {got[7:0], bits_q[b0+i]};
         chk({tag, "_bus_bits"}, got, e_bits);
      end
      if (e_err) begin
         chk({tag, "_pins_quiet"}, n_pinchg - c0, 0);
         chk({tag, "_no_bits"}, bits_q.size() - b0, 0);
      end
      chk({tag, "_starts"}, n_start - s0, (c == 2'd0 && !e_err) ? 1 : 0);
      chk({tag, "_stops"}, n_stop - p0, (c == 2'd3 && !e_err) ? 1 : 0);
      @(negedge clk);
      chk({tag, "_rsp_pulse"}, rsp_valid_o, 0);
      s_mode = 0;
   endtask

   initial begin
      int n, b0;
      logic seen;
      logic [1:0] op;
      rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_i = '0; wdata_i = '0; mack_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {cmd_ready_o, rsp_valid_o, rdata_o, ack_o, err_o, bus_active_o, scl_pull_o, sda_pull_o}, 0);
      rst_ni = 1'b1;
      chk("ready_first_cycle", cmd_ready_o, 0);
      @(negedge clk);
      chk("ready_after", cmd_ready_o, 1);

      run_cmd("illegal_write", 2'd1, 8'($urandom), 1'b0, 1'b1, 8'h00, 0);
      run_cmd("illegal_read", 2'd2, 8'h00, 1'($urandom), 1'b0, 8'($urandom), 0);
      run_cmd("illegal_stop", 2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      run_cmd("start", 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      run_cmd("write_a5", 2'd1, 8'hA5, 1'b0, 1'b1, 8'h00, 0);

      for (int k = 0; k < 10; k++) begin
         op = 2'($urandom_range(0, 2));
         if (op == 2'd0) run_cmd("rnd_restart", 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 0);
         else if (op == 2'd1) run_cmd("rnd_write", 2'd1, 8'($urandom), 1'b0, 1'($urandom), 8'h00, 0);
         else run_cmd("rnd_read", 2'd2, 8'h00, 1'($urandom), 1'b0, 8'($urandom), 0);
      end

      run_cmd("write_00_noack", 2'd1, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      run_cmd("read_3c", 2'd2, 8'h00, 1'b0, 1'b0, 8'h3C, 0);
      run_cmd("stop", 2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 0);

      run_cmd("start2", 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      st_req++;
      run_cmd("write_stretch", 2'd1, 8'($urandom), 1'b0, 1'b1, 8'h00, 50);
      run_cmd("stop2", 2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 0);

      run_cmd("start3", 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      s_mode = 2; s_tx = 8'($urandom);
      b0 = bits_q.size();
      cmd_i = 2'd2; mack_i = 1'b1; cmd_valid_i = 1'b1;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      n = 0;
      while (bits_q.size() < b0 + 5 && n < 1000) begin @(negedge clk); n++; end
      while (!scl_pull_o && n < 1000) begin @(negedge clk); n++; end
      chk("read_reached_bit4", n < 1000, 1);
      rst_ni = 1'b0;
      s_mode = 0;
      #1;
      chk("reset_mid_pins", {scl_pull_o, sda_pull_o}, 0);
      chk("reset_mid_bus", bus_active_o, 0);
      m_bus = 1'b0; m_rdata = 8'h00; m_ack = 1'b0;
      seen = 1'b0;
      repeat (5) begin @(negedge clk); seen = seen | rsp_valid_o; end
      rst_ni = 1'b1;
      repeat (3) begin @(negedge clk); seen = seen | rsp_valid_o; end
      chk("reset_mid_no_rsp", seen, 0);
      chk("reset_mid_ready", cmd_ready_o, 1);
      run_cmd("start_after_reset", 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      run_cmd("stop_after_reset", 2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
